// File: rtl/mtm_alu_packet_rx.sv
// -----------------------------------------------------------------------------
// mtm_alu_packet_rx
//
// Serial packet receiver for the mtm_alu protocol. It deserialises sin, one
// bit per clk, into 11-bit frames. Each frame on the wire, in order:
//   start(0), type(0 = data, 1 = CTL), d7..d0, stop(1).
// PAYLOAD_BYTES data frames followed by one CTL frame form a packet. Each
// packet is checked for length, framing and (optionally) CRC errors, and the
// result is queued in an output FIFO with a valid/ready handshake.
//
// Optional feature:
//   MTM_ALU_RX_CRC_EN  - when defined, a bit-serial CRC-4 (x^4+x+1, init 0)
//                        runs over the payload bits followed by
//                        {1'b1, ctl[6:4]} and is compared with ctl[3:0].
//                        When undefined, crc_err is constant 0.
//
// Parameters:
//   PAYLOAD_BYTES  data frames per packet (1..16)
//   FIFO_DEPTH     output FIFO entries (power of two, 2..16)
//
// Ports:
//   clk         system clock; sin is sampled on the rising edge
//   reset       synchronous, active-high reset
//   sin         serial input, idles high
//   pkt_valid   FIFO head entry is valid
//   pkt_ready   consumer accepts the head entry
//   pkt_data    payload; first received byte in the top byte
//   pkt_ctl     CTL byte (or the byte in flight on a framing error)
//   pkt_status  {frame_err, len_err, crc_err}; 000 = good packet
//   overflow    sticky; a packet was dropped because the FIFO was full
//   busy        FSM not in IDLE, or data frames are pending
// -----------------------------------------------------------------------------
module mtm_alu_packet_rx #(
  parameter int PAYLOAD_BYTES = 8,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sin,
  output logic                       pkt_valid,
  input  logic                       pkt_ready,
  output logic [PAYLOAD_BYTES*8-1:0] pkt_data,
  output logic [7:0]                 pkt_ctl,
  output logic [2:0]                 pkt_status,
  output logic                       overflow,
  output logic                       busy
);

  localparam int DW = PAYLOAD_BYTES * 8;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = 5;  // data count must reach 17 (16 + saturation)

  localparam logic [CW-1:0] LEN_FULL = CW'(PAYLOAD_BYTES);
  localparam logic [CW-1:0] LEN_SAT  = CW'(PAYLOAD_BYTES + 1);
  localparam logic [AW:0]   FILL_MAX = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    TYPE,
    BITS,
    STOP,
    RESYNC
  } state_e;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [7:0]    ctl;
    logic [2:0]    status;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Frame / packet assembly
  // ---------------------------------------------------------------------------
  state_e         state_q,   state_d;
  logic           type_q,    type_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q,   shift_d;
  logic [CW-1:0]  count_q,   count_d;
  logic [DW-1:0]  payload_q, payload_d;
  logic           crc_err;

  logic           push;
  entry_t         push_entry;

`ifdef MTM_ALU_RX_CRC_EN
  logic [3:0] crc_q, crc_d;
  logic       crc_in;
  logic       crc_fb;

  // The CTL byte contributes only its upper nibble, with its top bit replaced
  // by a constant 1 so an all-zero CTL still perturbs the remainder.
  always_comb begin
    crc_in = (type_q && (bit_cnt_q == 3'd0)) ? 1'b1 : sin;
    crc_fb = crc_q[3] ^ crc_in;
  end

  assign crc_err = (crc_q != shift_q[3:0]);
`else
  assign crc_err = 1'b0;
`endif

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case statement can leave a latch behind.
  always_comb begin
    state_d    = state_q;
    type_d     = type_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    count_d    = count_q;
    payload_d  = payload_q;
    push       = 1'b0;
    push_entry = '0;
`ifdef MTM_ALU_RX_CRC_EN
    crc_d      = crc_q;
`endif

    unique case (state_q)
      IDLE: begin
        bit_cnt_d = 3'd0;
        if (!sin) state_d = TYPE;
      end

      TYPE: begin
        type_d    = sin;
        bit_cnt_d = 3'd0;
        state_d   = BITS;
      end

      BITS: begin
        shift_d   = {shift_q[6:0], sin};
        bit_cnt_d = bit_cnt_q + 3'd1;
`ifdef MTM_ALU_RX_CRC_EN
        // Data frames feed all 8 bits; CTL frames feed only ctl[7:4].
        if (!type_q || !bit_cnt_q[2]) begin
          crc_d = {crc_q[2:0], 1'b0} ^ (crc_fb ? 4'b0011 : 4'b0000);
        end
`endif
        if (bit_cnt_q == 3'd7) state_d = STOP;
      end

      STOP: begin
        if (sin) begin
          state_d = IDLE;
          if (!type_q) begin
            // Shifting keeps the most recent bytes right-aligned, which
            // is exactly what a short or long packet reports.
            payload_d = (payload_q << 8) | DW'(shift_q);
            if (count_q != LEN_SAT) count_d = count_q + CW'(1);
          end else begin
            push              = 1'b1;
            push_entry.data   = payload_q;
            push_entry.ctl    = shift_q;
            push_entry.status = (count_q == LEN_FULL) ? {2'b00, crc_err}
                                                      : 3'b010;
            count_d   = '0;
            payload_d = '0;
`ifdef MTM_ALU_RX_CRC_EN
            crc_d     = '0;
`endif
          end
        end else begin
          push              = 1'b1;
          push_entry.ctl    = shift_q;
          push_entry.status = 3'b100;
          count_d   = '0;
          payload_d = '0;
`ifdef MTM_ALU_RX_CRC_EN
          crc_d     = '0;
`endif
          state_d   = RESYNC;
        end
      end

      RESYNC: begin
        if (sin) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      type_q    <= 1'b0;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      count_q   <= '0;
      payload_q <= '0;
`ifdef MTM_ALU_RX_CRC_EN
      crc_q     <= 4'h0;
`endif
    end else begin
      state_q   <= state_d;
      type_q    <= type_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      count_q   <= count_d;
      payload_q <= payload_d;
`ifdef MTM_ALU_RX_CRC_EN
      crc_q     <= crc_d;
`endif
    end
  end

  assign busy = (state_q != IDLE) || (count_q != '0);

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  entry_t        mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   fill_q,   fill_d;
  logic          overflow_q, overflow_d;
  logic          full;
  logic          pop;
  logic          wr_en;
  entry_t        head;

  always_comb begin
    full       = (fill_q == FILL_MAX);
    pop        = pkt_valid && pkt_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    wr_en      = push && (!full || pop);
    overflow_d = overflow_q || (push && full && !pop);
    wr_ptr_d   = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
    fill_d     = fill_q;
    if (wr_en && !pop)      fill_d = fill_q + (AW + 1)'(1);
    else if (!wr_en && pop) fill_d = fill_q - (AW + 1)'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: storage is not reset; the fill count marks which entries are live
  // and the outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head       = mem_q[rd_ptr_q];
  assign pkt_valid  = (fill_q != '0);
  assign pkt_data   = pkt_valid ? head.data   : '0;
  assign pkt_ctl    = pkt_valid ? head.ctl    : 8'h00;
  assign pkt_status = pkt_valid ? head.status : 3'b000;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_mtm_alu_packet_rx.sv
// -----------------------------------------------------------------------------
// tb_mtm_alu_packet_rx
//
// Directed testbench for mtm_alu_packet_rx with PAYLOAD_BYTES=8 and
// FIFO_DEPTH=4. Inputs change 1 ns after each rising edge and outputs are
// compared at that same point, away from the edge. Expected CRC values come
// from a polynomial long-division model that is independent of the RTL's
// shift-register form.
// -----------------------------------------------------------------------------
module tb_mtm_alu_packet_rx;

  localparam int PB = 8;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          sin;
  logic          pkt_valid;
  logic          pkt_ready;
  logic [63:0]   pkt_data;
  logic [7:0]    pkt_ctl;
  logic [2:0]    pkt_status;
  logic          overflow;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  mtm_alu_packet_rx #(
    .PAYLOAD_BYTES(PB),
    .FIFO_DEPTH   (FD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sin       (sin),
    .pkt_valid (pkt_valid),
    .pkt_ready (pkt_ready),
    .pkt_data  (pkt_data),
    .pkt_ctl   (pkt_ctl),
    .pkt_status(pkt_status),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Remainder of {payload, 1, op} * x^4 modulo x^4+x+1.
  function automatic logic [3:0] crc_model(input logic [63:0] pl,
                                           input logic [2:0] op);
    logic [71:0] m;
    m = {pl, 1'b1, op, 4'b0000};
    for (int i = 71; i >= 4; i--) begin
      if (m[i]) m[i -: 5] = m[i -: 5] ^ 5'b10011;
    end
    return m[3:0];
  endfunction

  function automatic logic [7:0] good_ctl(input logic [63:0] pl);
`ifdef MTM_ALU_RX_CRC_EN
    return {4'b0000, crc_model(pl, 3'b000)};
`else
    return 8'h00;
`endif
  endfunction

  task automatic send_bit(input logic b);
    sin = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic send_frame(input logic typ, input logic [7:0] b,
                            input logic stop_bit);
    send_bit(1'b0);
    send_bit(typ);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    send_bit(stop_bit);
  endtask

  task automatic send_packet(input logic [63:0] pl, input logic [7:0] ctl);
    for (int i = 0; i < PB; i++) send_frame(1'b0, pl[63-8*i -: 8], 1'b1);
    send_frame(1'b1, ctl, 1'b1);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  logic [63:0] pl;
  logic [63:0] fifo_exp [FD];
  logic [7:0]  ctl;

  initial begin
    reset     = 1'b1;
    sin       = 1'b1;
    pkt_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    check("rst_valid",    64'(pkt_valid),  64'd0);
    check("rst_data",     pkt_data,        64'd0);
    check("rst_ctl",      64'(pkt_ctl),    64'd0);
    check("rst_status",   64'(pkt_status), 64'd0);
    check("rst_overflow", 64'(overflow),   64'd0);
    check("rst_busy",     64'(busy),       64'd0);
    idle_cycles(2);

    // 1: good packet 00..07, entry visible right after the CTL stop edge
    pl  = 64'h0001020304050607;
    ctl = good_ctl(pl);
    send_packet(pl, ctl);
    check("t1_valid",  64'(pkt_valid),  64'd1);
    check("t1_data",   pkt_data,        pl);
    check("t1_ctl",    64'(pkt_ctl),    64'(ctl));
    check("t1_status", 64'(pkt_status), 64'd0);
    check("t1_busy",   64'(busy),       64'd0);
    send_bit(1'b1);
    check("t1_popped", 64'(pkt_valid),  64'd0);

`ifdef MTM_ALU_RX_CRC_EN
    // 2: all-ones payload with a deliberately wrong CRC nibble
    pl  = 64'hFFFFFFFFFFFFFFFF;
    ctl = {4'b0000, ~crc_model(pl, 3'b000)};
    send_packet(pl, ctl);
    check("t2_status", 64'(pkt_status), 64'd1);
    check("t2_data",   pkt_data,        pl);
    send_bit(1'b1);
`endif

    // 3a: short packet, 5 data frames
    for (int i = 0; i < 5; i++) send_frame(1'b0, 8'(8'hA1 + i), 1'b1);
    send_frame(1'b1, 8'h12, 1'b1);
    check("t3a_status", 64'(pkt_status), 64'd2);
    check("t3a_data",   pkt_data,        64'h000000A1A2A3A4A5);
    check("t3a_ctl",    64'(pkt_ctl),    64'h12);
    send_bit(1'b1);

    // 3b: long packet, 9 data frames; the last 8 bytes are reported
    for (int i = 0; i < 9; i++) send_frame(1'b0, 8'(8'h10 + i), 1'b1);
    send_frame(1'b1, 8'h00, 1'b1);
    check("t3b_status", 64'(pkt_status), 64'd2);
    check("t3b_data",   pkt_data,        64'h1112131415161718);
    send_bit(1'b1);

    // 3c: CTL with no preceding data is a length error
    send_frame(1'b1, 8'h34, 1'b1);
    check("t3c_status", 64'(pkt_status), 64'd2);
    check("t3c_data",   pkt_data,        64'd0);
    send_bit(1'b1);

    // 4: framing error on the 3rd data frame, then hold sin low
    send_frame(1'b0, 8'h30, 1'b1);
    send_frame(1'b0, 8'h31, 1'b1);
    send_frame(1'b0, 8'h32, 1'b0);
    check("t4_valid",  64'(pkt_valid),  64'd1);
    check("t4_status", 64'(pkt_status), 64'd4);
    check("t4_ctl",    64'(pkt_ctl),    64'h32);
    for (int i = 0; i < 20; i++) send_bit(1'b0);
    check("t4_resync_busy",  64'(busy),      64'd1);
    check("t4_resync_empty", 64'(pkt_valid), 64'd0);
    send_bit(1'b1);
    pl  = 64'h4041424344454647;
    ctl = good_ctl(pl);
    send_packet(pl, ctl);
    check("t4_good_status", 64'(pkt_status), 64'd0);
    check("t4_good_data",   pkt_data,        pl);
    send_bit(1'b1);

    // 5: back-pressure, FD+1 packets, last one dropped
    pkt_ready = 1'b0;
    for (int k = 0; k < FD + 1; k++) begin
      pl = {8{8'(8'h70 + k)}};
      if (k < FD) fifo_exp[k] = pl;
      send_packet(pl, good_ctl(pl));
      if (k == FD - 1) check("t5_no_ovf_yet", 64'(overflow), 64'd0);
    end
    check("t5_overflow", 64'(overflow),  64'd1);
    check("t5_valid",    64'(pkt_valid), 64'd1);
    idle_cycles(3);
    check("t5_stable", pkt_data, fifo_exp[0]);
    pkt_ready = 1'b1;
    for (int k = 0; k < FD; k++) begin
      check($sformatf("t5_pop%0d", k), pkt_data, fifo_exp[k]);
      send_bit(1'b1);
    end
    check("t5_drained", 64'(pkt_valid), 64'd0);
    check("t5_ovf_sticky", 64'(overflow), 64'd1);

    // 6: reset in the middle of the 4th data frame with an entry pending
    pkt_ready = 1'b0;
    pl = 64'h2122232425262728;
    send_packet(pl, good_ctl(pl));
    for (int i = 0; i < 3; i++) send_frame(1'b0, 8'(8'hE0 + i), 1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    pulse_reset();
    check("t6_valid",    64'(pkt_valid),  64'd0);
    check("t6_data",     pkt_data,        64'd0);
    check("t6_ctl",      64'(pkt_ctl),    64'd0);
    check("t6_status",   64'(pkt_status), 64'd0);
    check("t6_overflow", 64'(overflow),   64'd0);
    check("t6_busy",     64'(busy),       64'd0);
    pkt_ready = 1'b1;
    idle_cycles(2);
    pl  = 64'h5051525354555657;
    ctl = good_ctl(pl);
    send_packet(pl, ctl);
    check("t6_after_status", 64'(pkt_status), 64'd0);
    check("t6_after_data",   pkt_data,        pl);
    send_bit(1'b1);
    check("t6_after_pop", 64'(pkt_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
